mem_stage: RTL
==============

# mem_stage

Memory-access stage of the pipelined LEGv8 core, sitting directly downstream of the EX/MEM pipeline register and feeding the register-file write port. It issues LDUR/STUR accesses to the data memory over a valid/ready handshake, stalls the upstream pipeline while a multi-cycle access is outstanding, and registers write-back results into its internal MEM/WB register. Misaligned accesses and memory timeouts are aborted as bubbles and flagged.

## Interface
- TIMEOUT, 16: max consecutive WAIT cycles before an access is aborted (≥1).
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- ex_data  in  64  EX/MEM ALU result; memory address for loads/stores, write-back value otherwise.
- store_data  in  64  EX/MEM register-B value for STUR.
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  EX/MEM control bits.
- reg_write_addr  in  5  destination register.
- dmem_req  out  1  access request valid.
- dmem_we  out  1  1 = write (STUR), 0 = read.
- dmem_addr  out  64  equals ex_data.
- dmem_wdata  out  64  equals store_data.
- dmem_ready  in  1  memory accepts/completes the access this cycle.
- dmem_rdata  in  64  load data, valid when dmem_ready is high.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- mem_fault  out  1  one-cycle registered pulse on misalignment or timeout.
- wb_data_q  out  64  registered write-back value.
- RegWrite_q  out  1  registered register-file write enable.
- reg_write_addr_q  out  5  registered destination.

## Operation
- mem_op = MemRead | MemWrite; MemRead and MemWrite are never both set (upstream guarantees).
- misaligned = mem_op & (ex_data[2:0] != 0): no request issued; MEM/WB captures bubble (RegWrite_q=0); mem_fault pulses next cycle; no stall.
- FSM states IDLE, WAIT.
- IDLE, aligned mem_op: dmem_req=1 combinationally. dmem_ready=1 same cycle → complete, stay IDLE, no stall. Else stall=1, go WAIT, wait counter cleared.
- WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata held stable (inputs frozen by stall); stall=1 until completion. dmem_ready=1 → complete, stall=0, go IDLE. Counter reaches TIMEOUT-1 without ready → abort: dmem_req drops next cycle, stall=0 this cycle, bubble captured, mem_fault pulses next cycle, go IDLE.
- Non-memory instruction in IDLE: pass-through, no request, no stall.
- Completion capture: wb_data_q = MemtoReg ? dmem_rdata : ex_data; RegWrite_q = RegWrite; reg_write_addr_q = reg_write_addr. Stores capture RegWrite as given (0 from decode).
- Any cycle with stall=1 captures a bubble into MEM/WB (RegWrite_q=0, wb_data_q and reg_write_addr_q unchanged).
- dmem_ready while dmem_req=0 is ignored.

## Timing
- Reset: state IDLE, counter 0, wb_data_q=0, RegWrite_q=0, reg_write_addr_q=0, mem_fault=0; dmem_req and stall forced 0 in any cycle reset is high.
- Reset during WAIT abandons the access; no write-back, no fault.
- Zero-wait access: 1 cycle in stage, result visible on *_q the next cycle.
- N-wait access (ready in Nth WAIT cycle): N stall cycles, result on *_q the cycle after ready.
- Timeout: exactly TIMEOUT stall cycles, then abort.
- stall is combinational from state, mem_op, alignment, dmem_ready, counter.

## Structure
- legv8_pkg: mem_state_t enum {IDLE, WAIT}, DATA_W=64, REG_ADDR_W=5.
- Sub-module mem_wb_regs: MEM/WB pipeline register (64-bit data, 5-bit address, RegWrite, bubble-insert input), built from existing reg_64_bits, reg_5_bits, D_FF.
- FSM, wait counter ($clog2(TIMEOUT) bits), fault flop in mem_stage.

## Test plan
- ADD pass-through: RegWrite=1, ex_data=0x2A, addr 5 → no req, next cycle wb_data_q=0x2A, RegWrite_q=1, reg_write_addr_q=5.
- LDUR zero-wait: ex_data=0x100, MemRead=MemtoReg=1, dmem_ready=1, rdata=0xDEAD → stall never high, next cycle wb_data_q=0xDEAD.
- STUR 3-wait: ex_data=0x208, store_data=0x55, ready on 3rd WAIT cycle → stall high 3 cycles, dmem_we=1, addr/wdata stable, RegWrite_q=0 throughout.
- Misaligned LDUR ex_data=0x103 → dmem_req=0, RegWrite_q=0, mem_fault=1 for one cycle.
- Timeout with TIMEOUT=4, ready never high → stall exactly 4 cycles, req drops, mem_fault pulse, FSM IDLE; then reset asserted mid-WAIT of a new load → req and stall 0, no write-back.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and widths for the LEGv8 memory-access stage.
//   mem_state_t : access FSM states (IDLE, WAIT)
//   DATA_W      : datapath width
//   REG_ADDR_W  : register-file address width
package legv8_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus (valid/ready).
//   req   : access request valid        (master -> slave)
//   we    : 1 = write, 0 = read         (master -> slave)
//   addr  : byte address                (master -> slave)
//   wdata : store data                  (master -> slave)
//   ready : access accepted/completed   (slave -> master)
//   rdata : load data, valid with ready (slave -> master)
interface mem_stage_if;
    import legv8_pkg::*;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/D_FF.sv
// D_FF: single-bit register with load enable and synchronous active-high reset.
//   clk, reset, en : clock, reset, load enable
//   d, q           : data in / registered out
module D_FF (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= 1'b0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mem_wb_regs.sv
// mem_wb_regs: MEM/WB pipeline register.
//   clk, reset         : clock, synchronous active-high reset
//   load               : capture a completed instruction (all fields)
//   bubble             : insert a bubble (write enable cleared, data/addr held)
//   wb_data_d/_q       : write-back value
//   reg_write_d/_q     : register-file write enable
//   reg_write_addr_d/_q: destination register
module mem_wb_regs
    import legv8_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [DATA_W-1:0]     wb_data_d,
    input  logic                  reg_write_d,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_d,
    output logic [DATA_W-1:0]     wb_data_q,
    output logic                  reg_write_q,
    output logic [REG_ADDR_W-1:0] reg_write_addr_q
);
    logic rw_en;
    logic rw_d;

    // Load wins over bubble; a bubble only touches the write-enable bit.
    assign rw_en = load | bubble;
    assign rw_d  = load & reg_write_d;

    reg_64_bits u_data (.clk(clk), .reset(reset), .en(load),  .d(wb_data_d),        .q(wb_data_q));
    reg_5_bits  u_addr (.clk(clk), .reset(reset), .en(load),  .d(reg_write_addr_d), .q(reg_write_addr_q));
    D_FF        u_rw   (.clk(clk), .reset(reset), .en(rw_en), .d(rw_d),             .q(reg_write_q));
endmodule

// File: rtl/reg_5_bits.sv
// reg_5_bits: 5-bit register with load enable and synchronous active-high reset.
//   clk, reset, en : clock, reset, load enable
//   d, q           : data in / registered out
module reg_5_bits (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [4:0] d,
    output logic [4:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/reg_64_bits.sv
// reg_64_bits: 64-bit register with load enable and synchronous active-high reset.
//   clk, reset, en : clock, reset, load enable
//   d, q           : data in / registered out
module reg_64_bits (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] d,
    output logic [63:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LEGv8 memory-access stage. Issues LDUR/STUR over the dmem
// valid/ready bus, stalls upstream while an access is outstanding, aborts
// misaligned or timed-out accesses as flagged bubbles, and owns MEM/WB.
//   clk, reset                 : clock, synchronous active-high reset
//   ex_data, store_data        : EX/MEM ALU result / register-B value
//   MemRead..RegWrite          : EX/MEM control bits
//   reg_write_addr             : destination register
//   dmem                       : data-memory bus (master side)
//   stall                      : freeze upstream pipeline this cycle
//   mem_fault                  : one-cycle pulse after misalign/timeout
//   wb_data_q, RegWrite_q,
//   reg_write_addr_q           : MEM/WB register outputs
module mem_stage
    import legv8_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     ex_data,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] reg_write_addr,
    mem_stage_if.master           dmem,
    output logic                  stall,
    output logic                  mem_fault,
    output logic [DATA_W-1:0]     wb_data_q,
    output logic                  RegWrite_q,
    output logic [REG_ADDR_W-1:0] reg_write_addr_q
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_op, aligned;
    logic             req, complete, fault_d;

    assign mem_op  = MemRead | MemWrite;
    assign aligned = (ex_data[2:0] == 3'b000);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    complete = 1'b1;
                end else if (!aligned) begin
                    fault_d = 1'b1;
                end else begin
                    req = 1'b1;
                    if (dmem.ready) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                // Request stays up through the abort cycle; it drops once back in IDLE.
                req = 1'b1;
                if (dmem.ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            req      = 1'b0;
            stall    = 1'b0;
            complete = 1'b0;
            fault_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_fault <= fault_d;
        end
    end

    assign dmem.req   = req;
    assign dmem.we    = MemWrite;
    assign dmem.addr  = ex_data;
    assign dmem.wdata = store_data;

    // Every non-completing cycle (stall, misalign, abort) is a bubble.
    mem_wb_regs u_mem_wb (
        .clk              (clk),
        .reset            (reset),
        .load             (complete),
        .bubble           (~complete),
        .wb_data_d        (MemtoReg ? dmem.rdata : ex_data),
        .reg_write_d      (RegWrite),
        .reg_write_addr_d (reg_write_addr),
        .wb_data_q        (wb_data_q),
        .reg_write_q      (RegWrite_q),
        .reg_write_addr_q (reg_write_addr_q)
    );
endmodule
